// File: rtl/point_counter_ssd_driver.sv
// Four-digit saturating BCD point counter with active-low seven-segment encoding,
// leading-zero blanking and a rotating digit select for the downstream SSD mux.
module point_counter_ssd_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        dec,
    input  logic        clr,
    output logic [15:0] bcd,
    output logic        at_max,
    output logic        at_min,
    output logic [7:0]  display0,
    output logic [7:0]  display1,
    output logic [7:0]  display2,
    output logic [7:0]  display3,
    output logic [1:0]  ssd_ctl
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

    localparam logic [7:0] SegBlank = 8'hFF;
    localparam logic [7:0] SegZero  = 8'h03;

    logic [15:0]     bcd_q, bcd_d, bcd_inc, bcd_dec;
    logic [CntW-1:0] refresh_q;
    logic [1:0]      ssd_ctl_q;
    logic [7:0]      disp0_q, disp1_q, disp2_q, disp3_q;
    logic [7:0]      seg0_d, seg1_d, seg2_d, seg3_d;
    logic            carry, borrow;
    logic            blank1, blank2, blank3;

    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'h03;
            4'd1:    seg = 8'h9F;
            4'd2:    seg = 8'h25;
            4'd3:    seg = 8'h0D;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h49;
            4'd6:    seg = 8'h41;
            4'd7:    seg = 8'h1F;
            4'd8:    seg = 8'h01;
            4'd9:    seg = 8'h09;
            default: seg = SegBlank;
        endcase
        return seg;
    endfunction

    assign at_max = (bcd_q == 16'h9999);
    assign at_min = (bcd_q == 16'h0000);

    // Ripple increment: carry walks through every digit in the same cycle.
    always_comb begin
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_comb begin
        bcd_dec = bcd_q;
        borrow  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (bcd_q[4*i +: 4] == 4'd0) begin
                    bcd_dec[4*i +: 4] = 4'd9;
                end else begin
                    bcd_dec[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    always_comb begin
        bcd_d = bcd_q;
        if (clr) begin
            bcd_d = 16'h0000;
        end else if (inc && !dec && !at_max) begin
            bcd_d = bcd_inc;
        end else if (dec && !inc && !at_min) begin
            bcd_d = bcd_dec;
        end
    end

    // A digit blanks only when it and every more-significant digit are zero.
    always_comb begin
        blank3 = BLANK_LZ && (bcd_q[15:12] == 4'd0);
        blank2 = blank3 && (bcd_q[11:8] == 4'd0);
        blank1 = blank2 && (bcd_q[7:4] == 4'd0);
        seg0_d = seg_encode(bcd_q[3:0]);
        seg1_d = blank1 ? SegBlank : seg_encode(bcd_q[7:4]);
        seg2_d = blank2 ? SegBlank : seg_encode(bcd_q[11:8]);
        seg3_d = blank3 ? SegBlank : seg_encode(bcd_q[15:12]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q     <= 16'h0000;
            refresh_q <= '0;
            ssd_ctl_q <= 2'd0;
            disp0_q   <= SegZero;
            disp1_q   <= BLANK_LZ ? SegBlank : SegZero;
            disp2_q   <= BLANK_LZ ? SegBlank : SegZero;
            disp3_q   <= BLANK_LZ ? SegBlank : SegZero;
        end else begin
            bcd_q   <= bcd_d;
            disp0_q <= seg0_d;
            disp1_q <= seg1_d;
            disp2_q <= seg2_d;
            disp3_q <= seg3_d;
            if (refresh_q == CntLast) begin
                refresh_q <= '0;
                ssd_ctl_q <= ssd_ctl_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + 1'b1;
            end
        end
    end

    assign bcd      = bcd_q;
    assign display0 = disp0_q;
    assign display1 = disp1_q;
    assign display2 = disp2_q;
    assign display3 = disp3_q;
    assign ssd_ctl  = ssd_ctl_q;

endmodule

// File: tb/tb_point_counter_ssd_driver.sv
// Bench for point_counter_ssd_driver: decimal score model feeds an expectation queue,
// one task per scenario pops and compares after each clock edge.
module tb_point_counter_ssd_driver;

    localparam int unsigned Div = 4;

    logic        clk, rst, inc, dec, clr;
    logic [15:0] bcd, nz_bcd;
    logic        at_max, at_min, nz_at_max, nz_at_min;
    logic [7:0]  display0, display1, display2, display3;
    logic [7:0]  nz_display0, nz_display1, nz_display2, nz_display3;
    logic [1:0]  ssd_ctl, nz_ssd_ctl;

    point_counter_ssd_driver #(.REFRESH_DIV(Div), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr),
        .bcd(bcd), .at_max(at_max), .at_min(at_min),
        .display0(display0), .display1(display1), .display2(display2),
        .display3(display3), .ssd_ctl(ssd_ctl)
    );

    point_counter_ssd_driver #(.REFRESH_DIV(Div), .BLANK_LZ(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr),
        .bcd(nz_bcd), .at_max(nz_at_max), .at_min(nz_at_min),
        .display0(nz_display0), .display1(nz_display1), .display2(nz_display2),
        .display3(nz_display3), .ssd_ctl(nz_ssd_ctl)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        mx;
        logic        mn;
        logic [31:0] disp;     // {display3,display2,display1,display0}, blanking on
        logic [31:0] disp_nz;  // same, blanking off
        logic [1:0]  ctl;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   score, rcnt, rctl;
    int   vectors = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'h03;
            1: return 8'h9F;
            2: return 8'h25;
            3: return 8'h0D;
            4: return 8'h99;
            5: return 8'h49;
            6: return 8'h41;
            7: return 8'h1F;
            8: return 8'h01;
            9: return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [15:0] bcd_of(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // Apply one edge of stimulus and queue what the DUT must show just after it.
    task automatic drive(input logic r, input logic i, input logic d, input logic c);
        exp_t x;
        int   src;
        src = r ? 0 : score;
        rst = r; inc = i; dec = d; clr = c;
        if (r || c) score = 0;
        else if (i && !d && score < 9999) score++;
        else if (d && !i && score > 0) score--;
        if (r) begin
            rcnt = 0; rctl = 0;
        end else if (rcnt == Div - 1) begin
            rcnt = 0; rctl = (rctl + 1) % 4;
        end else begin
            rcnt++;
        end
        x.bcd  = bcd_of(score);
        x.mx   = (score == 9999);
        x.mn   = (score == 0);
        x.ctl  = 2'(rctl);
        x.disp = {(src < 1000) ? 8'hFF : seg_of(src / 1000),
                  (src < 100)  ? 8'hFF : seg_of((src / 100) % 10),
                  (src < 10)   ? 8'hFF : seg_of((src / 10) % 10),
                  seg_of(src % 10)};
        x.disp_nz = {seg_of(src / 1000), seg_of((src / 100) % 10),
                     seg_of((src / 10) % 10), seg_of(src % 10)};
        sb.push_back(x);
        @(posedge clk);
        #1;
        rst = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0);
        e = sb.pop_front();
        drive(1, 1, 0, 0);
        e = sb.pop_front();
        vectors++;
        if ({bcd, at_max, at_min} !== {16'h0000, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_bcd: got %h/%b/%b want 0000/0/1", bcd, at_max, at_min);
        end
        vectors++;
        if ({display3, display2, display1, display0, ssd_ctl} !== {e.disp, 2'd0}) begin
            miscompares++;
            $display("FAIL reset_disp: got %h %h %h %h ctl %0d want %h ctl 0",
                     display3, display2, display1, display0, ssd_ctl, e.disp);
        end
        vectors++;
        if ({nz_display3, nz_display2, nz_display1, nz_display0} !== 32'h03030303) begin
            miscompares++;
            $display("FAIL reset_disp_nz: got %h%h%h%h want 03030303",
                     nz_display3, nz_display2, nz_display1, nz_display0);
        end
        for (int k = 0; k < 17; k++) begin
            drive(0, 0, 0, 0);
            e = sb.pop_front();
            vectors++;
            if (ssd_ctl !== e.ctl) begin
                miscompares++;
                $display("FAIL refresh_ctl[%0d]: got %0d want %0d", k, ssd_ctl, e.ctl);
            end
        end
    endtask

    task automatic test_count();
        for (int k = 0; k < 12; k++) begin
            drive(0, 1, 0, 0);
            e = sb.pop_front();
            vectors++;
            if (bcd !== e.bcd) begin
                miscompares++;
                $display("FAIL count_bcd[%0d]: got %h want %h", k, bcd, e.bcd);
            end
        end
        drive(0, 0, 0, 0);
        e = sb.pop_front();
        vectors++;
        if ({bcd, display3, display2, display1, display0} !== {16'h0012, 32'hFFFF9F25}) begin
            miscompares++;
            $display("FAIL count_disp: got %h %h%h%h%h want 0012 FFFF9F25",
                     bcd, display3, display2, display1, display0);
        end
    endtask

    task automatic test_ripple();
        while (score < 999) begin
            drive(0, 1, 0, 0);
            e = sb.pop_front();
            vectors++;
            if (bcd !== e.bcd) begin
                miscompares++;
                $display("FAIL load_bcd: got %h want %h", bcd, e.bcd);
            end
        end
        drive(0, 1, 0, 0);
        e = sb.pop_front();
        vectors++;
        if (bcd !== 16'h1000 || e.bcd !== 16'h1000) begin
            miscompares++;
            $display("FAIL carry_bcd: got %h want 1000", bcd);
        end
        drive(0, 0, 0, 0);
        e = sb.pop_front();
        vectors++;
        if ({display3, display2, display1, display0} !== e.disp) begin
            miscompares++;
            $display("FAIL carry_disp: got %h%h%h%h want %h",
                     display3, display2, display1, display0, e.disp);
        end
        drive(0, 0, 1, 0);
        e = sb.pop_front();
        vectors++;
        if (bcd !== e.bcd) begin
            miscompares++;
            $display("FAIL borrow_bcd: got %h want %h", bcd, e.bcd);
        end
    endtask

    task automatic test_saturation();
        while (score < 9999) begin
            drive(0, 1, 0, 0);
            e = sb.pop_front();
            vectors++;
            if ({bcd, at_max} !== {e.bcd, e.mx}) begin
                miscompares++;
                $display("FAIL climb_bcd: got %h/%b want %h/%b", bcd, at_max, e.bcd, e.mx);
            end
        end
        drive(0, 1, 0, 0);
        e = sb.pop_front();
        vectors++;
        if ({bcd, at_max, at_min} !== {16'h9999, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sat_max: got %h/%b/%b want 9999/1/0", bcd, at_max, at_min);
        end
        drive(0, 0, 0, 0);
        e = sb.pop_front();
        vectors++;
        if ({display3, display2, display1, display0} !== e.disp) begin
            miscompares++;
            $display("FAIL sat_disp: got %h%h%h%h want %h",
                     display3, display2, display1, display0, e.disp);
        end
        drive(0, 0, 0, 1);
        e = sb.pop_front();
        drive(0, 0, 1, 0);
        e = sb.pop_front();
        vectors++;
        if ({bcd, at_max, at_min} !== {16'h0000, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL sat_min: got %h/%b/%b want 0000/0/1", bcd, at_max, at_min);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 0);
            e = sb.pop_front();
        end
        drive(0, 1, 1, 0);
        e = sb.pop_front();
        vectors++;
        if (bcd !== 16'h0005 || e.bcd !== 16'h0005) begin
            miscompares++;
            $display("FAIL inc_dec_hold: got %h want 0005", bcd);
        end
        drive(0, 1, 0, 1);
        e = sb.pop_front();
        vectors++;
        if (bcd !== 16'h0000) begin
            miscompares++;
            $display("FAIL clr_wins: got %h want 0000", bcd);
        end
        for (int k = 0; k < 42; k++) begin
            drive(0, 1, 0, 0);
            e = sb.pop_front();
            vectors++;
            if (bcd !== e.bcd) begin
                miscompares++;
                $display("FAIL recount_bcd[%0d]: got %h want %h", k, bcd, e.bcd);
            end
        end
        drive(0, 0, 0, 0);
        e = sb.pop_front();
        drive(1, 1, 0, 0);
        e = sb.pop_front();
        vectors++;
        if ({bcd, ssd_ctl, display3, display2, display1, display0} !==
            {16'h0000, 2'd0, 32'hFFFFFF03}) begin
            miscompares++;
            $display("FAIL mid_reset: got %h ctl %0d disp %h%h%h%h want 0000 ctl 0 FFFFFF03",
                     bcd, ssd_ctl, display3, display2, display1, display0);
        end
    endtask

    task automatic test_blank_off();
        for (int k = 0; k < 7; k++) begin
            drive(0, 1, 0, 0);
            e = sb.pop_front();
        end
        drive(0, 0, 0, 0);
        e = sb.pop_front();
        vectors++;
        if ({nz_bcd, nz_display3, nz_display2, nz_display1, nz_display0} !==
            {16'h0007, 32'h0303031F}) begin
            miscompares++;
            $display("FAIL blank_off: got %h %h%h%h%h want 0007 0303031F",
                     nz_bcd, nz_display3, nz_display2, nz_display1, nz_display0);
        end
        vectors++;
        if ({display3, display2, display1, display0} !== e.disp) begin
            miscompares++;
            $display("FAIL blank_on: got %h%h%h%h want %h",
                     display3, display2, display1, display0, e.disp);
        end
        vectors++;
        if (nz_ssd_ctl !== e.ctl) begin
            miscompares++;
            $display("FAIL blank_off_ctl: got %0d want %0d", nz_ssd_ctl, e.ctl);
        end
    endtask

    initial begin
        rst = 1'b1; inc = 1'b0; dec = 1'b0; clr = 1'b0;
        score = 0; rcnt = 0; rctl = 0;
        test_reset();
        test_count();
        test_ripple();
        test_saturation();
        test_back_to_back();
        test_blank_off();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
